ysyx_22040127_ifu: RTL and testbench
====================================

Name: ysyx_22040127_ifu

Overview:
Instruction fetch unit. Sits directly upstream of the decode stage.
- Owns the PC and issues 32-bit instruction fetches to the instruction memory over a valid/ready request and response interface.
- Buffers returned instructions in a small FIFO.
- Presents {instruction, pc} to decode with a valid/ready handshake.
- Accepts redirects from execute (branch/jump) and discards any stale in-flight fetch.

Parameters:
- RESET_PC, 64'h8000_0000, PC loaded at reset.
- XLEN, 64, PC and address width.
- DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (word aligned)
- imem_resp_valid  in  1  response data valid (always accepted)
- imem_resp_data  in  32  fetched instruction
- redirect_valid  in  1  control-flow redirect from execute
- redirect_pc  in  XLEN  redirect target
- inst_valid  out  1  buffered instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst_out  out  32  instruction word to decode
- inst_pc  out  XLEN  PC of inst_out

Behaviour:
Clocking and reset:
- One clock domain, clk.
- Reset rst is asynchronous, active-high.
- Reset values:
  - pc = RESET_PC; state = S_IDLE; FIFO empty; drop = 0.
  - imem_req_valid = 0; inst_valid = 0; inst_out = 0; inst_pc = 0.
  - imem_req_addr = RESET_PC.

State machine (one outstanding request max):
- S_IDLE: entered only from reset. Always goes to S_REQ next cycle.
- S_REQ:
  - imem_req_valid = 1 when the FIFO has at least one free slot (count < DEPTH); otherwise 0.
  - imem_req_addr = pc.
  - On a handshake (valid & ready): latch req_pc = pc, set pc <= pc + 4, go to S_WAIT.
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid:
    - If drop = 0, push {req_pc, imem_resp_data} into the FIFO.
    - If drop = 1, discard the response and clear drop.
    - Return to S_REQ.

Slot reservation:
- A request is issued only when a free slot exists, and only one request is outstanding.
- Therefore a push never overflows, even when no pop occurs in the same cycle.

Decode-side handshake:
- inst_valid = FIFO not empty; {inst_out, inst_pc} = FIFO head (registered storage).
- Pop on inst_valid & inst_ready.
- Latency: a response in cycle N gives inst_valid = 1 in cycle N+1 when the FIFO was empty. There is no combinational bypass.
- Push and pop may occur in the same cycle: count is unchanged and ordering is preserved.

Redirect (highest priority, evaluated every cycle):
- pc <= {redirect_pc[XLEN-1:2], 2'b00}. The low bits are forced to zero and are not trapped here.
- The FIFO is flushed: count = 0, and inst_valid = 0 next cycle.
- A pop in the same cycle is still a legal consumption by decode.
- In S_WAIT: set drop = 1. The pending response is discarded whenever it arrives.
- In S_REQ with a handshake in the same cycle: the request is stale. Go to S_WAIT with drop = 1; pc takes the redirect target, not +4.
- In S_WAIT with imem_resp_valid in the same cycle: the response is discarded, drop stays 0, and the state goes to S_REQ.
- Back-to-back redirects: the last one wins.

Wrap-around:
- pc + 4 wraps modulo 2^XLEN silently.
- FIFO read and write pointers wrap modulo DEPTH.

Reset mid-operation:
- Asynchronous reset wins immediately and forces all reset values.
- Any later memory response belonging to the pre-reset request is ignored in S_IDLE.
- In S_REQ, responses are ignored as well: resp_valid is only sampled in S_WAIT.

Decomposition:
- Shared package ysyx_22040127_pkg:
  - state encodings S_IDLE/S_REQ/S_WAIT;
  - default RESET_PC;
  - instruction width constant ILEN = 32.
- Sub-module ysyx_22040127_ifu_fifo:
  - parameterised DEPTH × (XLEN+32) synchronous FIFO;
  - ports: push, pop, flush, full, empty, count, head.
  - The FSM, PC and drop logic stay in the top.

Test Plan:
- Reset, then release with req_ready = 1 and 1-cycle response latency:
  - first request addr 0x80000000 in the second cycle after release;
  - then 0x80000004 and 0x80000008 in order;
  - inst_pc matches each address.
- Hold inst_ready = 0 while fetching:
  - exactly DEPTH = 2 instructions are buffered;
  - imem_req_valid stays 0 afterwards;
  - releasing inst_ready drains them in order and fetching resumes at 0x80000008.
- Set imem_req_ready = 0 for 5 cycles:
  - imem_req_valid stays 1;
  - imem_req_addr stays constant;
  - pc does not advance.
- Redirect to 0x80001000 while in S_WAIT for 0x80000004, with the response arriving 3 cycles later:
  - the response is dropped and the FIFO is flushed;
  - the next request is 0x80001000;
  - no instruction with pc 0x80000004 reaches decode.
- Redirect to 0x80002002 in the same cycle as a request handshake, and separately in the same cycle as a response:
  - both stale fetches are discarded;
  - the next fetch address is 0x80002000.
- Assert rst in S_WAIT, then deliver resp_valid after release:
  - the response is ignored;
  - fetching restarts at 0x80000000;
  - inst_valid = 0 until the new response arrives.

Source files
------------

// File: rtl/ysyx_22040127_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040127_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040127_pkg;

    // Fetch sequencer states; at most one memory request is outstanding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } ifu_state_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          ILEN             = 32;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040127_ifu_fifo
//  Description : Small synchronous FIFO holding {pc, instruction} entries.
//                Head is read straight from registered storage (no bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040127_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_push = push && (!full || pop);
    assign w_pop  = pop && !empty;

    // Entry storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040127_ifu
//  Description : Instruction fetch unit. Owns the PC, issues one fetch at a
//                time when a buffer slot is free, queues responses for decode
//                and discards stale fetches after a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040127_ifu
    import ysyx_22040127_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int               DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [ILEN-1:0]     imem_resp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [ILEN-1:0]     inst_out,
    output logic [XLEN-1:0]     inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = XLEN + ILEN;

    ifu_state_e       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             drop_q, drop_d;

    logic             w_hs;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [FW-1:0]    w_head;
    logic [XLEN-1:0]  w_redirect_pc;

    // Redirect targets are forced to word alignment; misalignment is not trapped here.
    assign w_redirect_pc  = redirect_pc & ~XLEN'(3);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = !w_empty;
    assign w_pop          = !w_empty && inst_ready;
    assign inst_out       = w_head[ILEN-1:0];
    assign inst_pc        = w_head[ILEN +: XLEN];

    // Sequencer: request issue, response capture, drop tracking and PC update.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        drop_d         = drop_q;
        imem_req_valid = 1'b0;
        w_hs           = 1'b0;
        w_push         = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // Only ask for an instruction we are guaranteed to have room for.
                imem_req_valid = (w_count < CW'(DEPTH));
                w_hs           = imem_req_valid && imem_req_ready;
                if (w_hs) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                    if (redirect_valid) begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    // A redirect arriving with the response kills it directly.
                    w_push  = !drop_q && !redirect_valid && !w_full;
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (redirect_valid) begin
            pc_d = w_redirect_pc;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    ysyx_22040127_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   ({req_pc_q, imem_resp_data}),
        .pop   (w_pop),
        .flush (redirect_valid),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22040127_ifu
//  Description : Self-checking bench for the instruction fetch unit with a
//                behavioural memory and an in-order fetch stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;

    int checks   = 0;
    int failures = 0;

    // Fetch-stream model: next fetch address, the one request in flight,
    // and the ordered list of instructions decode should see.
    logic [63:0] m_pc;
    bit          m_started;
    bit          m_out_valid;
    bit          m_stale;
    logic [63:0] m_out_addr;
    logic [63:0] exp_q[$];
    logic [63:0] hs_log[$];
    logic [63:0] pop_log[$];

    // Memory model: fixed-latency responder.
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = 64'h0;
    int          lat      = 1;

    ysyx_22040127_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memdata(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit exp_rv();
        return m_started && !m_out_valid && (exp_q.size() < DEPTH);
    endfunction

    task automatic reset_model(input bit keep_mem);
        m_pc        = RST_PC;
        m_started   = 1'b0;
        m_out_valid = 1'b0;
        m_stale     = 1'b0;
        m_out_addr  = 64'h0;
        exp_q.delete();
        hs_log.delete();
        pop_log.delete();
        if (!keep_mem) mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model(1'b0);
    endtask

    // One clock cycle: drive memory response, compare outputs to the model,
    // then advance model and memory by what happens at the coming edge.
    task automatic step();
        bit          hs, resp, pop, rdr;
        logic [63:0] tgt;
        imem_resp_valid = mem_busy && (mem_cnt == 0);
        imem_resp_data  = memdata(mem_addr);
        #1;
        checks++;
        if (inst_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL inst_valid @%0t: got %b expected %b", $time, inst_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if (inst_pc !== exp_q[0]) begin
                failures++;
                $display("FAIL inst_pc @%0t: got %h expected %h", $time, inst_pc, exp_q[0]);
            end
            checks++;
            if (inst_out !== memdata(exp_q[0])) begin
                failures++;
                $display("FAIL inst_out @%0t: got %h expected %h", $time, inst_out, memdata(exp_q[0]));
            end
        end
        checks++;
        if (imem_req_valid !== exp_rv()) begin
            failures++;
            $display("FAIL req_valid @%0t: got %b expected %b", $time, imem_req_valid, exp_rv());
        end
        checks++;
        if (imem_req_addr !== m_pc) begin
            failures++;
            $display("FAIL req_addr @%0t: got %h expected %h", $time, imem_req_addr, m_pc);
        end

        hs   = exp_rv() && imem_req_ready;
        resp = m_out_valid && imem_resp_valid;
        pop  = (exp_q.size() != 0) && inst_ready;
        rdr  = redirect_valid;
        tgt  = redirect_pc;
        if (hs)  hs_log.push_back(m_pc);
        if (pop) pop_log.push_back(exp_q[0]);

        if (imem_resp_valid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (hs) begin
            mem_busy = 1'b1;
            mem_cnt  = lat - 1;
            mem_addr = m_pc;
        end

        if (pop) void'(exp_q.pop_front());
        if (resp) begin
            if (!m_stale && !rdr) exp_q.push_back(m_out_addr);
            m_out_valid = 1'b0;
            m_stale     = 1'b0;
        end
        if (hs) begin
            m_out_valid = 1'b1;
            m_out_addr  = m_pc;
            m_stale     = rdr;
        end
        if (rdr) begin
            exp_q.delete();
            if (m_out_valid) m_stale = 1'b1;
        end
        if (rdr)     m_pc = tgt & ~64'd3;
        else if (hs) m_pc = m_pc + 64'd4;
        m_started = 1'b1;

        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        lat            = 1;
        run(5);
        // Assert reset between clock edges; outputs must react at once.
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        checks++;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
        checks++;
        if (inst_out !== 32'h0) begin failures++; $display("FAIL rst_inst_out: got %h expected 0", inst_out); end
        checks++;
        if (inst_pc !== 64'h0) begin failures++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
        checks++;
        if (imem_req_addr !== RST_PC) begin failures++; $display("FAIL rst_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model(1'b0);
    endtask

    task automatic test_sequential();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        run(10);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hs_log.size() <= i || hs_log[i] !== RST_PC + 64'(4 * i)) begin
                failures++;
                $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, (hs_log.size() > i) ? hs_log[i] : 64'hx, RST_PC + 64'(4 * i));
            end
            checks++;
            if (pop_log.size() <= i || pop_log[i] !== RST_PC + 64'(4 * i)) begin
                failures++;
                $display("FAIL seq_inst_pc[%0d]: got %h expected %h", i, (pop_log.size() > i) ? pop_log[i] : 64'hx, RST_PC + 64'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        lat            = 1;
        run(12);
        checks++;
        if (hs_log.size() != DEPTH) begin failures++; $display("FAIL bp_fetch_count: got %0d expected %0d", hs_log.size(), DEPTH); end
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
            failures++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=%h", inst_valid, inst_pc, RST_PC);
        end
        inst_ready = 1'b1;
        run(8);
        checks++;
        if (pop_log.size() < 2 || pop_log[0] !== RST_PC || pop_log[1] !== RST_PC + 64'd4) begin
            failures++; $display("FAIL bp_drain_order: got %0d entries expected %h,%h first", pop_log.size(), RST_PC, RST_PC + 64'd4);
        end
        checks++;
        if (hs_log.size() < 3 || hs_log[2] !== RST_PC + 64'd8) begin
            failures++; $display("FAIL bp_resume_addr: got %h expected %h", (hs_log.size() > 2) ? hs_log[2] : 64'hx, RST_PC + 64'd8);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        lat            = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b addr=%h expected v=1 addr=%h", i, imem_req_valid, imem_req_addr, RST_PC);
            end
        end
        imem_req_ready = 1'b1;
        run(3);
        checks++;
        if (hs_log.size() < 1 || hs_log[0] !== RST_PC) begin
            failures++; $display("FAIL stall_first_hs: got %h expected %h", (hs_log.size() > 0) ? hs_log[0] : 64'hx, RST_PC);
        end
    endtask

    task automatic test_redirect_wait();
        int guard;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        lat            = 1;
        guard = 0;
        while (hs_log.size() < 1 && guard < 20) begin step(); guard++; end
        lat = 4;
        while (hs_log.size() < 2 && guard < 20) begin step(); guard++; end
        if (hs_log.size() < 2) begin
            checks++; failures++; $display("FAIL rw_timeout: got %0d requests expected 2", hs_log.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        step();
        checks++;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL rw_flush: got inst_valid=%b expected 0", inst_valid); end
        lat        = 1;
        inst_ready = 1'b1;
        run(10);
        checks++;
        if (hs_log.size() < 3 || hs_log[2] !== 64'h8000_1000) begin
            failures++; $display("FAIL rw_next_addr: got %h expected 80001000", (hs_log.size() > 2) ? hs_log[2] : 64'hx);
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 64'h8000_1000) begin
            failures++; $display("FAIL rw_first_inst: got %h expected 80001000", (pop_log.size() > 0) ? pop_log[0] : 64'hx);
        end
        foreach (pop_log[i]) begin
            checks++;
            if (pop_log[i] == RST_PC + 64'd4 || pop_log[i] == RST_PC) begin
                failures++; $display("FAIL rw_stale_inst: got pc %h expected none from before redirect", pop_log[i]);
            end
        end
    endtask

    task automatic test_redirect_hs();
        int guard;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        guard = 0;
        while (!exp_rv() && guard < 20) begin step(); guard++; end
        if (!exp_rv()) begin checks++; failures++; $display("FAIL rh_timeout: got no request expected one"); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2002;
        step();
        run(8);
        checks++;
        if (hs_log.size() < 2 || hs_log[1] !== 64'h8000_2000) begin
            failures++; $display("FAIL rh_next_addr: got %h expected 80002000", (hs_log.size() > 1) ? hs_log[1] : 64'hx);
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 64'h8000_2000) begin
            failures++; $display("FAIL rh_first_inst: got %h expected 80002000", (pop_log.size() > 0) ? pop_log[0] : 64'hx);
        end
    endtask

    task automatic test_redirect_resp();
        int guard;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        guard = 0;
        while (!(m_out_valid && mem_busy && mem_cnt == 0) && guard < 20) begin step(); guard++; end
        if (!(m_out_valid && mem_busy && mem_cnt == 0)) begin
            checks++; failures++; $display("FAIL rr_timeout: got no pending response expected one");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2002;
        step();
        run(8);
        checks++;
        if (hs_log.size() < 2 || hs_log[1] !== 64'h8000_2000) begin
            failures++; $display("FAIL rr_next_addr: got %h expected 80002000", (hs_log.size() > 1) ? hs_log[1] : 64'hx);
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 64'h8000_2000) begin
            failures++; $display("FAIL rr_first_inst: got %h expected 80002000", (pop_log.size() > 0) ? pop_log[0] : 64'hx);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 2;
        guard = 0;
        while (!m_out_valid && guard < 20) begin step(); guard++; end
        if (!m_out_valid) begin checks++; failures++; $display("FAIL rm_timeout: got no request expected one"); end
        lat = 1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model(1'b1);
        step();
        step();
        checks++;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL rm_stale_resp: got inst_valid=%b expected 0", inst_valid); end
        run(4);
        checks++;
        if (hs_log.size() < 1 || hs_log[0] !== RST_PC) begin
            failures++; $display("FAIL rm_restart_addr: got %h expected %h", (hs_log.size() > 0) ? hs_log[0] : 64'hx, RST_PC);
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== RST_PC) begin
            failures++; $display("FAIL rm_first_inst: got %h expected %h", (pop_log.size() > 0) ? pop_log[0] : 64'hx, RST_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            lat            = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else
                    redirect_pc = RST_PC + 64'($urandom_range(0, 4095));
            end
            step();
        end
        checks++;
        if (pop_log.size() < 100) begin
            failures++; $display("FAIL rand_progress: got %0d instructions expected at least 100", pop_log.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_req_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_redirect_resp();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
